// File: rtl/cla_seq_adder.sv
// Multi-cycle add/subtract unit that reuses one SLICE-bit carry-look-ahead
// slice, working LSB slice first and carrying between slices in a register.
module cla_seq_adder #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int NGROUP = SLICE / 4;
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic             carry;
  logic [IW-1:0]    idx;

  logic [SLICE-1:0] a_s;
  logic [SLICE-1:0] b_s;
  logic [SLICE-1:0] g;
  logic [SLICE-1:0] p;
  logic [SLICE:0]   c;
  logic [NGROUP-1:0] gg;
  logic [NGROUP-1:0] pg;

  // Status flags are pure decodes of the registered state.
  assign busy = (state == RUN);
  assign done = (state == DONE);

  // One look-ahead slice: 4-bit groups with internal look-ahead, chained
  // through group generate/propagate, then the accumulator with this slice merged in.
  always_comb begin
    a_s = a_reg[idx*SLICE +: SLICE];
    b_s = b_reg[idx*SLICE +: SLICE];
    g   = a_s & b_s;
    p   = a_s ^ b_s;
    c   = '0;
    gg  = '0;
    pg  = '0;
    c[0] = carry;
    for (int k = 0; k < NGROUP; k++) begin
      c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
      c[4*k+2] = g[4*k+1] | (g[4*k] & p[4*k+1])
               | (p[4*k] & p[4*k+1] & c[4*k]);
      c[4*k+3] = g[4*k+2] | (g[4*k+1] & p[4*k+2])
               | (g[4*k] & p[4*k+1] & p[4*k+2])
               | (p[4*k] & p[4*k+1] & p[4*k+2] & c[4*k]);
      gg[k] = g[4*k+3] | (g[4*k+2] & p[4*k+3])
            | (g[4*k+1] & p[4*k+2] & p[4*k+3])
            | (g[4*k] & p[4*k+1] & p[4*k+2] & p[4*k+3]);
      pg[k] = p[4*k] & p[4*k+1] & p[4*k+2] & p[4*k+3];
      c[4*k+4] = gg[k] | (pg[k] & c[4*k]);
    end
    acc_next = acc;
    acc_next[idx*SLICE +: SLICE] = p ^ c[SLICE-1:0];
  end

  // Sequencer: latch operands on accept, one slice per clock, publish on the last slice.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_reg <= a;
            b_reg <= sub ? ~b : b;
            carry <= sub;
            idx   <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc   <= acc_next;
          carry <= c[SLICE];
          idx   <= idx + IW'(1);
          if (idx == LAST_IDX) begin
            sum   <= acc_next;
            cout  <= c[SLICE];
            ovf   <= c[SLICE] ^ c[SLICE-1];
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed and random checks for cla_seq_adder with default 32/8 parameters.
module tb_cla_seq_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sub;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  cla_seq_adder #(.WIDTH(32), .SLICE(8)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present an operation with start high and let it be accepted at the next edge.
  task automatic applyStimulus(input logic [31:0] av, input logic [31:0] bv, input logic sv,
                               input logic keepStart);
    a = av;
    b = bv;
    sub = sv;
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!keepStart) start = 1'b0;
  endtask

  // Count cycles from the sample after the accept edge until done, bounded.
  task automatic waitDone(output int lat, output int busyCycles);
    lat = 0;
    busyCycles = 0;
    while (!done && lat < 20) begin
      if (busy) busyCycles++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic refModel(input logic [31:0] av, input logic [31:0] bv, input logic sv,
                          output logic [31:0] es, output logic ec, output logic eo);
    logic [32:0] full;
    logic [31:0] bb;
    bb = sv ? ~bv : bv;
    full = {1'b0, av} + {1'b0, bb} + {32'd0, sv};
    es = full[31:0];
    ec = full[32];
    eo = (av[31] == bb[31]) && (es[31] != av[31]);
  endtask

  task automatic runOp(input string tag, input logic [31:0] av, input logic [31:0] bv,
                       input logic sv, input logic [31:0] es, input logic ec, input logic eo);
    int lat;
    int bc;
    applyStimulus(av, bv, sv, 1'b0);
    waitDone(lat, bc);
    checkOutput({tag, "_latency"}, 32'(lat), 32'd4);
    checkOutput({tag, "_sum"}, sum, es);
    checkOutput({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
    checkOutput({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
    @(posedge clk);
    #1;
    checkOutput({tag, "_done_width"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int lat;
    int bc;
    int ndone;
    logic [31:0] ra, rb, es;
    logic rs, ec, eo;

    rst = 1'b1;
    start = 1'b0;
    sub = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_sum", sum, 32'd0);
    checkOutput("reset_cout", {31'd0, cout}, 32'd0);
    checkOutput("reset_ovf", {31'd0, ovf}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Carry out of the full width, with busy width check.
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    waitDone(lat, bc);
    checkOutput("carry_latency", 32'(lat), 32'd4);
    checkOutput("carry_busy_cycles", 32'(bc), 32'd4);
    checkOutput("carry_sum", sum, 32'h0000_0000);
    checkOutput("carry_cout", {31'd0, cout}, 32'd1);
    checkOutput("carry_ovf", {31'd0, ovf}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("carry_done_width", {31'd0, done}, 32'd0);
    checkOutput("carry_sum_hold", sum, 32'h0000_0000);

    runOp("pos_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    runOp("neg_ovf", 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    runOp("borrow", 32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    runOp("cross_slice", 32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 1'b0, 1'b0);

    // Back-to-back with start held high; operands switch to the next op during RUN.
    applyStimulus(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1);
    a = 32'h0000_0010;
    b = 32'h0000_0020;
    sub = 1'b1;
    waitDone(lat, bc);
    checkOutput("b2b1_latency", 32'(lat), 32'd4);
    checkOutput("b2b1_sum", sum, 32'h2345_6789);
    checkOutput("b2b1_cout", {31'd0, cout}, 32'd0);
    @(posedge clk);
    #1;
    a = 32'hDEAD_BEEF;
    b = 32'hCAFE_F00D;
    sub = 1'b0;
    checkOutput("b2b_reaccept_busy", {31'd0, busy}, 32'd1);
    waitDone(lat, bc);
    start = 1'b0;
    checkOutput("b2b_spacing", 32'(lat + 1), 32'd5);
    checkOutput("b2b2_sum", sum, 32'hFFFF_FFF0);
    checkOutput("b2b2_cout", {31'd0, cout}, 32'd0);
    checkOutput("b2b2_ovf", {31'd0, ovf}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("b2b_idle_after", {31'd0, busy | done}, 32'd0);

    // Reset during the second RUN cycle discards the operation.
    applyStimulus(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    checkOutput("midrst_done", {31'd0, done}, 32'd0);
    checkOutput("midrst_sum", sum, 32'd0);
    checkOutput("midrst_cout", {31'd0, cout}, 32'd0);
    checkOutput("midrst_ovf", {31'd0, ovf}, 32'd0);
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    checkOutput("midrst_no_done", 32'(ndone), 32'd0);
    runOp("after_rst", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0);

    // Random operations against the reference model.
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      refModel(ra, rb, rs, es, ec, eo);
      runOp("rand", ra, rb, rs, es, ec, eo);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
